// File: rtl/pe_seq_pkg.sv
// Shared types and sizes for the PE sequencer.
package pe_seq_pkg;

    localparam int unsigned PE_DEPTH = 8;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned IDX_W    = 3;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PE_DEPTH - 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_CLR     = 4'd1,
        S_SHIFT   = 4'd2,
        S_RD_REQ  = 4'd3,
        S_RD_WAIT = 4'd4,
        S_WR      = 4'd5,
        S_COMP    = 4'd6,
        S_CAPT    = 4'd7,
        S_OUT     = 4'd8,
        S_FIN     = 4'd9
    } state_e;

    typedef enum logic {
        PH_W = 1'b0,
        PH_A = 1'b1
    } phase_e;

endpackage

// File: rtl/gb_rd_port.sv
// Global-buffer read port: one outstanding request, registered issue,
// combinational ack/data back to the sequencer when the read returns.
module gb_rd_port
    import pe_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] addr,
    output logic              gb_rd_en,
    output logic [ADDR_W-1:0] gb_addr,
    input  logic              gb_rvalid,
    input  logic [DATA_W-1:0] gb_rdata,
    output logic              ack_c,
    output logic [DATA_W-1:0] data_c
);

    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              pend_q,  pend_d;

    // Returned data is only accepted against a request still in flight.
    assign ack_c  = pend_q & gb_rvalid;
    assign data_c = gb_rdata;

    assign gb_rd_en = rd_en_q;
    assign gb_addr  = addr_q;

    // Issue strobe, held address and outstanding-request tracking.
    always_comb begin
        rd_en_d = req;
        addr_d  = addr_q;
        pend_d  = pend_q;
        if (req) begin
            addr_d = addr;
        end
        if (ack_c) begin
            pend_d = 1'b0;
        end
        if (rd_en_q) begin
            pend_d = 1'b1;
        end
    end

    // Port registers; reset drops any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: rtl/pe_seq_ctrl.sv
// PE sequencer: clears the PE, loads weights/activations from the global
// buffer, runs the 8-cycle compute and hands each window result to the
// final-add stage. Sliding windows reuse weights and load one activation.
// Optional statistics counters: define PE_SEQ_STATS_EN.
module pe_seq_ctrl
    import pe_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [CNT_W-1:0]  num_out,
    output logic              busy,
    output logic              done,
    output logic              gb_rd_en,
    output logic [ADDR_W-1:0] gb_addr,
    input  logic [DATA_W-1:0] gb_rdata,
    input  logic              gb_rvalid,
    output logic              pe_write_w,
    output logic              pe_write_a,
    output logic              pe_comp,
    output logic              pe_shift,
    output logic              pe_clear,
    output logic [IDX_W-1:0]  pe_comp_idx,
    output logic [IDX_W-1:0]  pe_write_idx,
    output logic [DATA_W-1:0] pe_data_in,
    input  logic [DATA_W-1:0] pe_data_out,
    output logic              res_valid,
    output logic [DATA_W-1:0] res_data,
    output logic [CNT_W-1:0]  res_idx,
    input  logic              res_ready
`ifdef PE_SEQ_STATS_EN
    ,
    output logic [31:0]       stat_busy_cyc,
    output logic [31:0]       stat_stall_cyc
`endif
);

    state_e            state_q, state_d;
    phase_e            phase_q, phase_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [CNT_W-1:0]  win_q, win_d;
    logic [CNT_W-1:0]  num_out_q, num_out_d;
    logic [ADDR_W-1:0] w_base_q, w_base_d;
    logic [ADDR_W-1:0] a_base_q, a_base_d;

    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pe_write_w_q, pe_write_w_d;
    logic              pe_write_a_q, pe_write_a_d;
    logic              pe_comp_q, pe_comp_d;
    logic              pe_shift_q, pe_shift_d;
    logic              pe_clear_q, pe_clear_d;
    logic [IDX_W-1:0]  pe_comp_idx_q, pe_comp_idx_d;
    logic [IDX_W-1:0]  pe_write_idx_q, pe_write_idx_d;
    logic [DATA_W-1:0] pe_data_in_q, pe_data_in_d;
    logic              res_valid_q, res_valid_d;
    logic [DATA_W-1:0] res_data_q, res_data_d;
    logic [CNT_W-1:0]  res_idx_q, res_idx_d;

    logic              rd_req_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic              rd_ack_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              start_acc_c;
    logic [CNT_W:0]    win_next_c;

    gb_rd_port #(
        .ADDR_W (ADDR_W)
    ) u_gb_rd_port (
        .clk       (clk),
        .rst       (rst),
        .req       (rd_req_c),
        .addr      (rd_addr_c),
        .gb_rd_en  (gb_rd_en),
        .gb_addr   (gb_addr),
        .gb_rvalid (gb_rvalid),
        .gb_rdata  (gb_rdata),
        .ack_c     (rd_ack_c),
        .data_c    (rd_data_c)
    );

    assign start_acc_c = (state_q == S_IDLE) && start;
    assign win_next_c  = {1'b0, win_q} + (CNT_W+1)'(1);

    // Next-state logic; outputs are derived from the next state so they
    // line up with the state register.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        k_d       = k_q;
        win_d     = win_q;
        num_out_d = num_out_q;
        w_base_d  = w_base_q;
        a_base_d  = a_base_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    w_base_d  = w_base;
                    a_base_d  = a_base;
                    num_out_d = num_out;
                    win_d     = '0;
                    state_d   = (num_out == '0) ? S_FIN : S_CLR;
                end
            end
            S_CLR: begin
                if (win_q == '0) begin
                    phase_d = PH_W;
                    k_d     = '0;
                    state_d = S_RD_REQ;
                end else begin
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                phase_d = PH_A;
                k_d     = IDX_LAST;
                state_d = S_RD_REQ;
            end
            S_RD_REQ: begin
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (rd_ack_c) begin
                    state_d = S_WR;
                end
            end
            S_WR: begin
                if (k_q != IDX_LAST) begin
                    k_d     = k_q + IDX_W'(1);
                    state_d = S_RD_REQ;
                end else if (phase_q == PH_W) begin
                    phase_d = PH_A;
                    k_d     = '0;
                    state_d = S_RD_REQ;
                end else begin
                    k_d     = '0;
                    state_d = S_COMP;
                end
            end
            S_COMP: begin
                if (k_q == IDX_LAST) begin
                    state_d = S_CAPT;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            S_CAPT: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                if (res_ready) begin
                    win_d   = win_q + CNT_W'(1);
                    state_d = (win_next_c < {1'b0, num_out_q}) ? S_CLR : S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        rd_req_c  = (state_d == S_RD_REQ);
        rd_addr_c = (phase_d == PH_W) ? (w_base_d + ADDR_W'(k_d))
                                      : (a_base_d + ADDR_W'(k_d) + ADDR_W'(win_d));

        busy_d       = (state_d != S_IDLE) && (state_d != S_FIN);
        done_d       = (state_d == S_FIN);
        pe_clear_d   = (state_d == S_CLR);
        pe_shift_d   = (state_d == S_SHIFT);
        pe_write_w_d = (state_d == S_WR) && (phase_d == PH_W);
        pe_write_a_d = (state_d == S_WR) && (phase_d == PH_A);
        pe_comp_d    = (state_d == S_COMP);
        pe_comp_idx_d = (state_d == S_COMP) ? k_d : '0;

        // Index stays nonzero during compute so the PE accumulates.
        pe_write_idx_d = pe_write_idx_q;
        if (state_d == S_WR) begin
            pe_write_idx_d = k_d;
        end else if (state_d == S_COMP) begin
            pe_write_idx_d = IDX_LAST;
        end

        pe_data_in_d = pe_data_in_q;
        if ((state_q == S_RD_WAIT) && rd_ack_c) begin
            pe_data_in_d = rd_data_c;
        end

        res_valid_d = (state_d == S_OUT);
        res_data_d  = res_data_q;
        res_idx_d   = res_idx_q;
        if (state_q == S_CAPT) begin
            res_data_d = pe_data_out;
            res_idx_d  = win_q;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            phase_q        <= PH_W;
            k_q            <= '0;
            win_q          <= '0;
            num_out_q      <= '0;
            w_base_q       <= '0;
            a_base_q       <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            pe_write_w_q   <= 1'b0;
            pe_write_a_q   <= 1'b0;
            pe_comp_q      <= 1'b0;
            pe_shift_q     <= 1'b0;
            pe_clear_q     <= 1'b0;
            pe_comp_idx_q  <= '0;
            pe_write_idx_q <= '0;
            pe_data_in_q   <= '0;
            res_valid_q    <= 1'b0;
            res_data_q     <= '0;
            res_idx_q      <= '0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            k_q            <= k_d;
            win_q          <= win_d;
            num_out_q      <= num_out_d;
            w_base_q       <= w_base_d;
            a_base_q       <= a_base_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            pe_write_w_q   <= pe_write_w_d;
            pe_write_a_q   <= pe_write_a_d;
            pe_comp_q      <= pe_comp_d;
            pe_shift_q     <= pe_shift_d;
            pe_clear_q     <= pe_clear_d;
            pe_comp_idx_q  <= pe_comp_idx_d;
            pe_write_idx_q <= pe_write_idx_d;
            pe_data_in_q   <= pe_data_in_d;
            res_valid_q    <= res_valid_d;
            res_data_q     <= res_data_d;
            res_idx_q      <= res_idx_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign pe_write_w   = pe_write_w_q;
    assign pe_write_a   = pe_write_a_q;
    assign pe_comp      = pe_comp_q;
    assign pe_shift     = pe_shift_q;
    assign pe_clear     = pe_clear_q;
    assign pe_comp_idx  = pe_comp_idx_q;
    assign pe_write_idx = pe_write_idx_q;
    assign pe_data_in   = pe_data_in_q;
    assign res_valid    = res_valid_q;
    assign res_data     = res_data_q;
    assign res_idx      = res_idx_q;

`ifdef PE_SEQ_STATS_EN
    logic [31:0] stat_busy_q, stat_busy_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating busy/stall cycle counters, cleared when a job is accepted.
    always_comb begin
        stat_busy_d  = stat_busy_q;
        stat_stall_d = stat_stall_q;
        if (start_acc_c) begin
            stat_busy_d  = '0;
            stat_stall_d = '0;
        end else begin
            if (busy_q && (stat_busy_q != '1)) begin
                stat_busy_d = stat_busy_q + 32'd1;
            end
            if (res_valid_q && !res_ready && (stat_stall_q != '1)) begin
                stat_stall_d = stat_stall_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_busy_q  <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_busy_q  <= stat_busy_d;
            stat_stall_q <= stat_stall_d;
        end
    end

    assign stat_busy_cyc  = stat_busy_q;
    assign stat_stall_cyc = stat_stall_q;
`endif

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// Directed bench for pe_seq_ctrl with a behavioural GB and PE model.
module tb_pe_seq_ctrl;

    localparam int unsigned ADDR_W = 16;
    localparam int unsigned CNT_W  = 8;

    localparam logic [63:0] F1  = 64'h3FF0000000000000;
    localparam logic [63:0] F2  = 64'h4000000000000000;
    localparam logic [63:0] F16 = 64'h4030000000000000;
    localparam logic [63:0] F28 = 64'h403C000000000000;
    localparam logic [63:0] F36 = 64'h4042000000000000;
    localparam logic [63:0] F44 = 64'h4046000000000000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [ADDR_W-1:0] w_base = '0;
    logic [ADDR_W-1:0] a_base = '0;
    logic [CNT_W-1:0]  num_out = '0;
    logic              busy, done, gb_rd_en;
    logic [ADDR_W-1:0] gb_addr;
    logic [63:0]       gb_rdata = '0;
    logic              gb_rvalid = 1'b0;
    logic              pe_write_w, pe_write_a, pe_comp, pe_shift, pe_clear;
    logic [2:0]        pe_comp_idx, pe_write_idx;
    logic [63:0]       pe_data_in;
    logic [63:0]       pe_data_out = '0;
    logic              res_valid;
    logic [63:0]       res_data;
    logic [CNT_W-1:0]  res_idx;
    logic              res_ready = 1'b1;
`ifdef PE_SEQ_STATS_EN
    logic [31:0]       stat_busy_cyc, stat_stall_cyc;
`endif

    pe_seq_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .w_base       (w_base),
        .a_base       (a_base),
        .num_out      (num_out),
        .busy         (busy),
        .done         (done),
        .gb_rd_en     (gb_rd_en),
        .gb_addr      (gb_addr),
        .gb_rdata     (gb_rdata),
        .gb_rvalid    (gb_rvalid),
        .pe_write_w   (pe_write_w),
        .pe_write_a   (pe_write_a),
        .pe_comp      (pe_comp),
        .pe_shift     (pe_shift),
        .pe_clear     (pe_clear),
        .pe_comp_idx  (pe_comp_idx),
        .pe_write_idx (pe_write_idx),
        .pe_data_in   (pe_data_in),
        .pe_data_out  (pe_data_out),
        .res_valid    (res_valid),
        .res_data     (res_data),
        .res_idx      (res_idx),
        .res_ready    (res_ready)
`ifdef PE_SEQ_STATS_EN
        ,
        .stat_busy_cyc  (stat_busy_cyc),
        .stat_stall_cyc (stat_stall_cyc)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [14:0] ctl_vec;
    assign ctl_vec = {busy, done, gb_rd_en, pe_write_w, pe_write_a, pe_comp, pe_shift,
                      pe_clear, res_valid, pe_comp_idx, pe_write_idx};

    // GB model: fixed or random latency, logs every request.
    logic [63:0]       mem [256];
    int                lat_min = 1, lat_max = 1;
    bit                pend = 1'b0;
    int                rem = 0;
    logic [ADDR_W-1:0] pend_addr = '0;
    logic [ADDR_W-1:0] rd_q [$];
    int                multi_out = 0;

    always @(negedge clk) begin
        gb_rvalid = 1'b0;
        if (pend) begin
            rem--;
            if (rem == 0) begin
                gb_rvalid = 1'b1;
                gb_rdata  = mem[pend_addr[7:0]];
                pend      = 1'b0;
            end
        end
        if (gb_rd_en) begin
            if (pend) multi_out++;
            pend      = 1'b1;
            rem       = $urandom_range(lat_max, lat_min);
            pend_addr = gb_addr;
            rd_q.push_back(gb_addr);
        end
    end

    // PE model plus strobe/activity/result monitors.
    real         pw [8];
    real         pa [8];
    real         psum = 0.0;
    logic [3:0]  wr_q [$];
    logic [63:0] rq_data [$];
    logic [7:0]  rq_idx [$];
    int          onehot_err = 0, act_cnt = 0, clr_cnt = 0, shf_cnt = 0;

    always @(negedge clk) begin
        if ((32'(pe_write_w) + 32'(pe_write_a) + 32'(pe_comp) + 32'(pe_shift) + 32'(pe_clear)) > 1)
            onehot_err++;
        if (gb_rd_en || pe_write_w || pe_write_a || pe_comp || pe_shift || pe_clear) act_cnt++;
        if (pe_clear) begin
            clr_cnt++;
            psum = 0.0;
            pe_data_out = '0;
        end
        if (pe_shift) begin
            shf_cnt++;
            for (int i = 0; i < 7; i++) pa[i] = pa[i+1];
        end
        if (pe_write_w) pw[pe_write_idx] = $bitstoreal(pe_data_in);
        if (pe_write_a) pa[pe_write_idx] = $bitstoreal(pe_data_in);
        if (pe_write_w || pe_write_a) wr_q.push_back({pe_write_a, pe_write_idx});
        if (pe_comp) begin
            psum = psum + pw[pe_comp_idx] * pa[pe_comp_idx];
            pe_data_out = $realtobits(psum);
        end
        if (res_valid && res_ready) begin
            rq_data.push_back(res_data);
            rq_idx.push_back(res_idx);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        rq_data.delete();
        rq_idx.delete();
        clr_cnt = 0;
        shf_cnt = 0;
    endtask

    task automatic start_job(input logic [15:0] wb, input logic [15:0] ab, input logic [7:0] n);
        w_base  = wb;
        a_base  = ab;
        num_out = n;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    // which: 0 res_valid, 1 done, 2 pe_comp
    task automatic wait_for(input int which, input int budget, output int n);
        logic s;
        n = 0;
        s = 1'b0;
        while (n < budget) begin
            step();
            n++;
            s = (which == 0) ? res_valid : (which == 1) ? done : pe_comp;
            if (s) return;
        end
        chk($sformatf("wait_timeout_%0d", which), 64'(s), 64'd1);
    endtask

    task automatic check_reads(input string tag, input int first, input logic [15:0] base, input int cnt);
        for (int i = 0; i < cnt; i++)
            chk($sformatf("%s_rd%0d", tag, first + i), 64'(rd_q[first + i]), 64'(base + 16'(i)));
    endtask

    int n;
    logic [63:0] snap_data;
    logic [7:0]  snap_idx;
    int          snap_act;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        for (int i = 0; i < 8; i++) begin
            pw[i] = 0.0;
            pa[i] = 0.0;
        end

        // Reset state
        step();
        step();
        chk("reset_ctl", 64'(ctl_vec), 64'd0);
        chk("reset_addr", 64'(gb_addr), 64'd0);
        chk("reset_pdin", pe_data_in, 64'd0);
        chk("reset_res", res_data, 64'd0);
        chk("reset_ridx", 64'(res_idx), 64'd0);
        rst = 1'b0;
        step();

        // 1. Single window, L=1
        for (int i = 0; i < 8; i++) begin
            mem[8'h10 + i] = F1;
            mem[8'h40 + i] = F2;
        end
        clear_logs();
        start_job(16'h10, 16'h40, 8'd1);
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_clr_first", 64'(pe_clear), 64'd1);
        wait_for(0, 200, n);
        chk("t1_latency", 64'(n), 64'd58);
        chk("t1_data", res_data, F16);
        chk("t1_idx", 64'(res_idx), 64'd0);
        wait_for(1, 20, n);
        chk("t1_done_busy", 64'(busy), 64'd0);
`ifdef PE_SEQ_STATS_EN
        chk("t1_stat_busy", 64'(stat_busy_cyc), 64'd59);
`endif
        step();
        chk("t1_done_pulse", 64'(done), 64'd0);
        chk("t1_nreads", 64'(rd_q.size()), 64'd16);
        check_reads("t1w", 0, 16'h10, 8);
        check_reads("t1a", 8, 16'h40, 8);
        chk("t1_nwr", 64'(wr_q.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t1_wr%0d", i), 64'(wr_q[i]), 64'({i >= 8, 3'(i)}));

        // 2. Sliding windows, acts[i]=i
        for (int i = 0; i < 10; i++) mem[8'h40 + i] = $realtobits(real'(i));
        clear_logs();
        start_job(16'h10, 16'h40, 8'd3);
        wait_for(1, 600, n);
        step();
        chk("t2_nreads", 64'(rd_q.size()), 64'd18);
        chk("t2_rd16", 64'(rd_q[16]), 64'h48);
        chk("t2_rd17", 64'(rd_q[17]), 64'h49);
        chk("t2_wr16", 64'(wr_q[16]), 64'hF);
        chk("t2_wr17", 64'(wr_q[17]), 64'hF);
        chk("t2_nclr", 64'(clr_cnt), 64'd3);
        chk("t2_nshift", 64'(shf_cnt), 64'd2);
        chk("t2_nres", 64'(rq_data.size()), 64'd3);
        chk("t2_res0", rq_data[0], F28);
        chk("t2_res1", rq_data[1], F36);
        chk("t2_res2", rq_data[2], F44);
        chk("t2_idx0", 64'(rq_idx[0]), 64'd0);
        chk("t2_idx1", 64'(rq_idx[1]), 64'd1);
        chk("t2_idx2", 64'(rq_idx[2]), 64'd2);

        // 3. Backpressure for 10 cycles
        clear_logs();
        res_ready = 1'b0;
        start_job(16'h10, 16'h40, 8'd2);
        wait_for(0, 200, n);
        snap_data = res_data;
        snap_idx  = res_idx;
        snap_act  = act_cnt;
        chk("t3_data0", snap_data, F28);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("t3_valid%0d", c), 64'(res_valid), 64'd1);
            chk($sformatf("t3_data%0d", c), res_data, F28);
            chk($sformatf("t3_idx%0d", c), 64'(res_idx), 64'd0);
        end
        chk("t3_quiet", 64'(act_cnt), 64'(snap_act));
        res_ready = 1'b1;
        wait_for(1, 200, n);
`ifdef PE_SEQ_STATS_EN
        chk("t3_stat_stall", 64'(stat_stall_cyc), 64'd10);
`endif
        step();
        chk("t3_nres", 64'(rq_data.size()), 64'd2);
        chk("t3_res1", rq_data[1], F36);
        chk("t3_idx1", 64'(rq_idx[1]), 64'd1);

        // 4. Random GB latency 1..5
        lat_min = 1;
        lat_max = 5;
        clear_logs();
        start_job(16'h10, 16'h40, 8'd2);
        wait_for(1, 2000, n);
        step();
        lat_max = 1;
        chk("t4_nwr", 64'(wr_q.size()), 64'd17);
        for (int i = 0; i < 16; i++)
            chk($sformatf("t4_wr%0d", i), 64'(wr_q[i]), 64'({i >= 8, 3'(i)}));
        chk("t4_wr16", 64'(wr_q[16]), 64'hF);
        check_reads("t4w", 0, 16'h10, 8);
        check_reads("t4a", 8, 16'h40, 9);
        chk("t4_res0", rq_data[0], F28);
        chk("t4_res1", rq_data[1], F36);
        chk("t4_outstanding", 64'(multi_out), 64'd0);

        // 5. num_out=0 and start while busy
        clear_logs();
        start_job(16'h10, 16'h40, 8'd0);
        chk("t5_zero_done", 64'(done), 64'd1);
        chk("t5_zero_busy", 64'(busy), 64'd0);
        step();
        chk("t5_zero_pulse", 64'(done), 64'd0);
        step();
        chk("t5_zero_reads", 64'(rd_q.size()), 64'd0);
        start_job(16'h10, 16'h40, 8'd1);
        step();
        step();
        start_job(16'h20, 16'h60, 8'd3);
        wait_for(1, 300, n);
        step();
        for (int c = 0; c < 5; c++) step();
        chk("t5_idle", 64'(busy), 64'd0);
        chk("t5_nreads", 64'(rd_q.size()), 64'd16);
        check_reads("t5w", 0, 16'h10, 8);
        chk("t5_nres", 64'(rq_data.size()), 64'd1);
        chk("t5_res", rq_data[0], F28);

        // 6. Reset during compute, then restart
        clear_logs();
        start_job(16'h10, 16'h40, 8'd1);
        wait_for(2, 300, n);
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_ctl", 64'(ctl_vec), 64'd0);
        chk("t6_pdin", pe_data_in, 64'd0);
        chk("t6_res", res_data, 64'd0);
        chk("t6_addr", 64'(gb_addr), 64'd0);
        rst = 1'b0;
        step();
        clear_logs();
        start_job(16'h10, 16'h40, 8'd1);
        chk("t6_clr_first", 64'(pe_clear), 64'd1);
        wait_for(1, 300, n);
        step();
        chk("t6_nres", 64'(rq_data.size()), 64'd1);
        chk("t6_res0", rq_data[0], F28);
        chk("t6_idx0", 64'(rq_idx[0]), 64'd0);

        chk("onehot", 64'(onehot_err), 64'd0);
        chk("one_outstanding", 64'(multi_out), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
